writeback_top: RTL and testbench

- Final pipeline stage; sits directly downstream of the memory-access stage and consumes its wb_dat / wb_inst / wb_pc outputs.
- Owns the architectural integer register file (x0..x31) and provides the two decode-stage read ports, with write-through bypass.
- Maintains retire/cycle counters, the last-retired PC, and a sticky record of memory-stage exceptions.

---
 rtl/writeback_top_if.sv | 32 +++
 rtl/writeback_top.sv | 103 ++++++++++
 tb/tb_writeback_top.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_top_if.sv
// Bundle between the memory-access/decode stages and the writeback stage.
// The writeback stage takes the slave side; the neighbouring stages (or a bench) take the master side.
interface writeback_top_if #(
    parameter int CNT_W = 64
);
    logic [31:0]      mem_dat;
    logic [31:0]      mem_inst;
    logic [31:0]      mem_pc;
    logic             mem_exc_mis;
    logic             mem_exc_oob;
    logic             exc_clr;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic [31:0]      id_rd1;
    logic [31:0]      id_rd2;
    logic             rf_we;
    logic [4:0]       rf_dst;
    logic [31:0]      retire_pc;
    logic [CNT_W-1:0] cnt_cycle;
    logic [CNT_W-1:0] cnt_instret;
    logic [1:0]       exc_sticky;

    modport master (
        output mem_dat, mem_inst, mem_pc, mem_exc_mis, mem_exc_oob, exc_clr, id_rs1, id_rs2,
        input  id_rd1, id_rd2, rf_we, rf_dst, retire_pc, cnt_cycle, cnt_instret, exc_sticky
    );

    modport slave (
        input  mem_dat, mem_inst, mem_pc, mem_exc_mis, mem_exc_oob, exc_clr, id_rs1, id_rs2,
        output id_rd1, id_rd2, rf_we, rf_dst, retire_pc, cnt_cycle, cnt_instret, exc_sticky
    );
endinterface

// File: rtl/writeback_top.sv
// Writeback stage: integer register file with write-through read ports, retire/cycle
// counters, last-retired PC and sticky memory-exception flags.
module writeback_top #(
    parameter int CNT_W  = 64,
    parameter bit RF_RST = 1'b1
) (
    input logic            clk,
    input logic            rst_n,
    writeback_top_if.slave wb
);

    localparam logic [31:0]      BUBBLE  = 32'h0000_0013;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [6:0]       opcode;
    logic [4:0]       rd;
    logic             wr_opcode;
    logic             retired;
    logic             rf_we;
    logic [31:0]      rf_q [32];
    logic [31:0]      rd1;
    logic [31:0]      rd2;
    logic [CNT_W-1:0] cnt_cycle_q;
    logic [CNT_W-1:0] cnt_cycle_d;
    logic [CNT_W-1:0] cnt_instret_q;
    logic [CNT_W-1:0] cnt_instret_d;
    logic [31:0]      retire_pc_q;
    logic [31:0]      retire_pc_d;
    logic [1:0]       exc_q;
    logic [1:0]       exc_d;

    assign opcode  = wb.mem_inst[6:0];
    assign rd      = wb.mem_inst[11:7];
    assign retired = (wb.mem_inst != BUBBLE);

    always_comb begin
        wr_opcode = 1'b0;
        case (opcode)
            7'b0000011, 7'b0010011, 7'b0110011, 7'b0110111,
            7'b0010111, 7'b1101111, 7'b1100111: wr_opcode = 1'b1;
            default:                            wr_opcode = 1'b0;
        endcase
    end

    assign rf_we     = wr_opcode && (rd != 5'd0) && retired;
    assign wb.rf_we  = rf_we;
    assign wb.rf_dst = rd;

    // Entry 0 is never written; the read muxes force x0 to zero instead.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if (RF_RST) begin
                for (int i = 0; i < 32; i++) begin
                    rf_q[i] <= '0;
                end
            end
        end else if (rf_we) begin
            rf_q[rd] <= wb.mem_dat;
        end
    end

    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (wb.id_rs1 != 5'd0) begin
            rd1 = (rf_we && (wb.id_rs1 == rd)) ? wb.mem_dat : rf_q[wb.id_rs1];
        end
        if (wb.id_rs2 != 5'd0) begin
            rd2 = (rf_we && (wb.id_rs2 == rd)) ? wb.mem_dat : rf_q[wb.id_rs2];
        end
    end

    assign wb.id_rd1 = rd1;
    assign wb.id_rd2 = rd2;

    // A new exception in the same cycle as a clear wins, so no event is dropped.
    always_comb begin
        cnt_cycle_d   = cnt_cycle_q + CNT_ONE;
        cnt_instret_d = retired ? (cnt_instret_q + CNT_ONE) : cnt_instret_q;
        retire_pc_d   = retired ? wb.mem_pc : retire_pc_q;
        exc_d         = (exc_q & ~{2{wb.exc_clr}}) | {wb.mem_exc_oob, wb.mem_exc_mis};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_cycle_q   <= '0;
            cnt_instret_q <= '0;
            retire_pc_q   <= '0;
            exc_q         <= '0;
        end else begin
            cnt_cycle_q   <= cnt_cycle_d;
            cnt_instret_q <= cnt_instret_d;
            retire_pc_q   <= retire_pc_d;
            exc_q         <= exc_d;
        end
    end

    assign wb.cnt_cycle   = cnt_cycle_q;
    assign wb.cnt_instret = cnt_instret_q;
    assign wb.retire_pc   = retire_pc_q;
    assign wb.exc_sticky  = exc_q;

endmodule

// File: tb/tb_writeback_top.sv
// Directed bench for writeback_top: dut_a (32-bit counters, cleared RF) and dut_b
// (64-bit counters, RF kept across reset) see identical stimulus.
module tb_writeback_top;

    localparam logic [31:0] BUBBLE = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    writeback_top_if #(.CNT_W(32)) wb_a ();
    writeback_top_if #(.CNT_W(64)) wb_b ();

    assign wb_b.mem_dat     = wb_a.mem_dat;
    assign wb_b.mem_inst    = wb_a.mem_inst;
    assign wb_b.mem_pc      = wb_a.mem_pc;
    assign wb_b.mem_exc_mis = wb_a.mem_exc_mis;
    assign wb_b.mem_exc_oob = wb_a.mem_exc_oob;
    assign wb_b.exc_clr     = wb_a.exc_clr;
    assign wb_b.id_rs1      = wb_a.id_rs1;
    assign wb_b.id_rs2      = wb_a.id_rs2;

    writeback_top #(.CNT_W(32), .RF_RST(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .wb(wb_a));
    writeback_top #(.CNT_W(64), .RF_RST(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .wb(wb_b));

    task automatic drive(input logic [31:0] inst, input logic [31:0] dat, input logic [31:0] pc);
        wb_a.mem_inst = inst;
        wb_a.mem_dat  = dat;
        wb_a.mem_pc   = pc;
    endtask

    // Holds reset over two rising edges and returns at the negedge where it is released.
    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(BUBBLE, 32'h0, 32'h0);
        wb_a.mem_exc_mis = 1'b0;
        wb_a.mem_exc_oob = 1'b0;
        wb_a.exc_clr     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        wb_a.id_rs1 = 5'd5;
        wb_a.id_rs2 = 5'd31;
        #1;
        tests++; if (wb_a.cnt_cycle !== 32'd0) begin fails++; $display("[TB] FAIL rst_cycle_a: got %0d expected 0", wb_a.cnt_cycle); end
        tests++; if (wb_b.cnt_cycle !== 64'd0) begin fails++; $display("[TB] FAIL rst_cycle_b: got %0d expected 0", wb_b.cnt_cycle); end
        tests++; if (wb_a.cnt_instret !== 32'd0) begin fails++; $display("[TB] FAIL rst_instret: got %0d expected 0", wb_a.cnt_instret); end
        tests++; if (wb_a.retire_pc !== 32'd0) begin fails++; $display("[TB] FAIL rst_retire_pc: got %h expected 0", wb_a.retire_pc); end
        tests++; if (wb_a.exc_sticky !== 2'b00) begin fails++; $display("[TB] FAIL rst_exc: got %b expected 00", wb_a.exc_sticky); end
        tests++; if (wb_a.id_rd1 !== 32'd0) begin fails++; $display("[TB] FAIL rst_rd1: got %h expected 0", wb_a.id_rd1); end
        tests++; if (wb_a.id_rd2 !== 32'd0) begin fails++; $display("[TB] FAIL rst_rd2: got %h expected 0", wb_a.id_rd2); end
        repeat (10) @(negedge clk);
        #1;
        tests++; if (wb_a.cnt_cycle !== 32'd10) begin fails++; $display("[TB] FAIL cycle10_a: got %0d expected 10", wb_a.cnt_cycle); end
        tests++; if (wb_b.cnt_cycle !== 64'd10) begin fails++; $display("[TB] FAIL cycle10_b: got %0d expected 10", wb_b.cnt_cycle); end
        tests++; if (wb_a.cnt_instret !== 32'd0) begin fails++; $display("[TB] FAIL bubble_instret: got %0d expected 0", wb_a.cnt_instret); end
        tests++; if (wb_a.retire_pc !== 32'd0) begin fails++; $display("[TB] FAIL bubble_retire_pc: got %h expected 0", wb_a.retire_pc); end
    endtask

    task automatic test_write_bypass();
        @(negedge clk);
        drive(32'h0000_0293, 32'hDEAD_BEEF, 32'h0000_0100);
        wb_a.id_rs1 = 5'd5;
        wb_a.id_rs2 = 5'd5;
        #1;
        tests++; if (wb_a.rf_we !== 1'b1) begin fails++; $display("[TB] FAIL addi_we: got %b expected 1", wb_a.rf_we); end
        tests++; if (wb_a.rf_dst !== 5'd5) begin fails++; $display("[TB] FAIL addi_dst: got %0d expected 5", wb_a.rf_dst); end
        tests++; if (wb_a.id_rd1 !== 32'hDEAD_BEEF) begin fails++; $display("[TB] FAIL bypass_rd1: got %h expected deadbeef", wb_a.id_rd1); end
        tests++; if (wb_a.id_rd2 !== 32'hDEAD_BEEF) begin fails++; $display("[TB] FAIL bypass_rd2: got %h expected deadbeef", wb_a.id_rd2); end
        @(negedge clk);
        drive(BUBBLE, 32'h0, 32'hFFFF_0000);
        #1;
        tests++; if (wb_a.rf_we !== 1'b0) begin fails++; $display("[TB] FAIL bubble_we: got %b expected 0", wb_a.rf_we); end
        tests++; if (wb_a.id_rd1 !== 32'hDEAD_BEEF) begin fails++; $display("[TB] FAIL stored_x5: got %h expected deadbeef", wb_a.id_rd1); end
        tests++; if (wb_a.cnt_instret !== 32'd1) begin fails++; $display("[TB] FAIL addi_instret: got %0d expected 1", wb_a.cnt_instret); end
        tests++; if (wb_a.retire_pc !== 32'h0000_0100) begin fails++; $display("[TB] FAIL addi_retire_pc: got %h expected 100", wb_a.retire_pc); end
    endtask

    task automatic test_x0();
        @(negedge clk);
        drive(32'h1230_0013, 32'h1234_5678, 32'h0000_0104);
        wb_a.id_rs1 = 5'd0;
        wb_a.id_rs2 = 5'd0;
        #1;
        tests++; if (wb_a.rf_we !== 1'b0) begin fails++; $display("[TB] FAIL x0_we: got %b expected 0", wb_a.rf_we); end
        tests++; if (wb_a.id_rd1 !== 32'd0) begin fails++; $display("[TB] FAIL x0_rd1_same: got %h expected 0", wb_a.id_rd1); end
        tests++; if (wb_a.id_rd2 !== 32'd0) begin fails++; $display("[TB] FAIL x0_rd2_same: got %h expected 0", wb_a.id_rd2); end
        @(negedge clk);
        drive(BUBBLE, 32'h0, 32'h0);
        #1;
        tests++; if (wb_a.id_rd1 !== 32'd0) begin fails++; $display("[TB] FAIL x0_rd1_next: got %h expected 0", wb_a.id_rd1); end
        tests++; if (wb_a.id_rd2 !== 32'd0) begin fails++; $display("[TB] FAIL x0_rd2_next: got %h expected 0", wb_a.id_rd2); end
        tests++; if (wb_a.cnt_instret !== 32'd2) begin fails++; $display("[TB] FAIL x0_instret: got %0d expected 2", wb_a.cnt_instret); end
        tests++; if (wb_a.retire_pc !== 32'h0000_0104) begin fails++; $display("[TB] FAIL x0_retire_pc: got %h expected 104", wb_a.retire_pc); end
    endtask

    // Store and branch carry a nonzero bit pattern in the rd field to prove they never write.
    task automatic test_store_branch();
        @(negedge clk);
        drive(32'h0051_22A3, 32'hFFFF_FFFF, 32'h0000_0108);
        wb_a.id_rs1 = 5'd5;
        #1;
        tests++; if (wb_a.rf_we !== 1'b0) begin fails++; $display("[TB] FAIL store_we: got %b expected 0", wb_a.rf_we); end
        tests++; if (wb_a.id_rd1 !== 32'hDEAD_BEEF) begin fails++; $display("[TB] FAIL store_rd1: got %h expected deadbeef", wb_a.id_rd1); end
        @(negedge clk);
        drive(32'h0000_02E3, 32'hFFFF_FFFF, 32'h0000_010C);
        #1;
        tests++; if (wb_a.rf_we !== 1'b0) begin fails++; $display("[TB] FAIL branch_we: got %b expected 0", wb_a.rf_we); end
        @(negedge clk);
        drive(BUBBLE, 32'h0, 32'h0);
        #1;
        tests++; if (wb_a.id_rd1 !== 32'hDEAD_BEEF) begin fails++; $display("[TB] FAIL sb_x5_kept: got %h expected deadbeef", wb_a.id_rd1); end
        tests++; if (wb_a.cnt_instret !== 32'd4) begin fails++; $display("[TB] FAIL sb_instret: got %0d expected 4", wb_a.cnt_instret); end
        tests++; if (wb_a.retire_pc !== 32'h0000_010C) begin fails++; $display("[TB] FAIL sb_retire_pc: got %h expected 10c", wb_a.retire_pc); end
    endtask

    task automatic test_opcodes();
        logic [6:0]  opc [8] = '{7'h03, 7'h33, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h73, 7'h7F};
        logic        we  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [4:0]  rdv;
        logic [31:0] dat;
        logic [31:0] exp_rd;
        for (int i = 0; i < 8; i++) begin
            rdv = 5'(10 + i);
            dat = 32'h1000_0000 | 32'(i);
            @(negedge clk);
            drive({20'h0, rdv, opc[i]}, dat, 32'h0000_0200);
            #1;
            tests++; if (wb_a.rf_we !== we[i]) begin fails++; $display("[TB] FAIL opc_we[%0d]: got %b expected %b", i, wb_a.rf_we, we[i]); end
            tests++; if (wb_a.rf_dst !== rdv) begin fails++; $display("[TB] FAIL opc_dst[%0d]: got %0d expected %0d", i, wb_a.rf_dst, rdv); end
            @(negedge clk);
            drive(BUBBLE, 32'h0, 32'h0);
            wb_a.id_rs2 = rdv;
            exp_rd = we[i] ? dat : 32'h0;
            #1;
            tests++; if (wb_a.id_rd2 !== exp_rd) begin fails++; $display("[TB] FAIL opc_store[%0d]: got %h expected %h", i, wb_a.id_rd2, exp_rd); end
        end
    endtask

    task automatic test_exceptions();
        @(negedge clk);
        wb_a.mem_exc_mis = 1'b1;
        @(negedge clk);
        wb_a.mem_exc_mis = 1'b0;
        #1;
        tests++; if (wb_a.exc_sticky !== 2'b01) begin fails++; $display("[TB] FAIL exc_set_mis: got %b expected 01", wb_a.exc_sticky); end
        @(negedge clk);
        #1;
        tests++; if (wb_a.exc_sticky !== 2'b01) begin fails++; $display("[TB] FAIL exc_hold: got %b expected 01", wb_a.exc_sticky); end
        wb_a.exc_clr     = 1'b1;
        wb_a.mem_exc_oob = 1'b1;
        @(negedge clk);
        wb_a.exc_clr     = 1'b0;
        wb_a.mem_exc_oob = 1'b0;
        #1;
        tests++; if (wb_a.exc_sticky !== 2'b10) begin fails++; $display("[TB] FAIL exc_clr_set: got %b expected 10", wb_a.exc_sticky); end
        wb_a.exc_clr = 1'b1;
        @(negedge clk);
        wb_a.exc_clr = 1'b0;
        #1;
        tests++; if (wb_a.exc_sticky !== 2'b00) begin fails++; $display("[TB] FAIL exc_clr: got %b expected 00", wb_a.exc_sticky); end
    endtask

    // Preloads dut_a's 32-bit retire counter to all-ones, then retires once.
    task automatic test_counter_wrap();
        @(negedge clk);
        drive(BUBBLE, 32'h0, 32'h0);
        force dut_a.cnt_instret_d = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut_a.cnt_instret_d;
        #1;
        tests++; if (wb_a.cnt_instret !== 32'hFFFF_FFFF) begin fails++; $display("[TB] FAIL wrap_preload: got %h expected ffffffff", wb_a.cnt_instret); end
        drive(32'h0051_2023, 32'h0, 32'h0000_0400);
        @(negedge clk);
        drive(BUBBLE, 32'h0, 32'h0);
        #1;
        tests++; if (wb_a.cnt_instret !== 32'd0) begin fails++; $display("[TB] FAIL wrap_instret: got %h expected 0", wb_a.cnt_instret); end
        tests++; if (wb_a.retire_pc !== 32'h0000_0400) begin fails++; $display("[TB] FAIL wrap_retire_pc: got %h expected 400", wb_a.retire_pc); end
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        drive(32'h0000_0393, 32'hA5A5_A5A5, 32'h0000_0300);
        wb_a.id_rs1 = 5'd7;
        @(negedge clk);
        drive(32'h0000_0393, 32'h0000_0001, 32'h0000_0304);
        rst_n = 1'b0;
        #1;
        tests++; if (wb_a.rf_we !== 1'b1) begin fails++; $display("[TB] FAIL rstcyc_we: got %b expected 1", wb_a.rf_we); end
        tests++; if (wb_a.id_rd1 !== 32'h0000_0001) begin fails++; $display("[TB] FAIL rstcyc_bypass: got %h expected 1", wb_a.id_rd1); end
        @(negedge clk);
        rst_n = 1'b1;
        drive(BUBBLE, 32'h0, 32'h0);
        #1;
        tests++; if (wb_a.id_rd1 !== 32'h0) begin fails++; $display("[TB] FAIL rst_x7_cleared: got %h expected 0", wb_a.id_rd1); end
        tests++; if (wb_b.id_rd1 !== 32'hA5A5_A5A5) begin fails++; $display("[TB] FAIL rst_x7_kept: got %h expected a5a5a5a5", wb_b.id_rd1); end
        tests++; if (wb_a.cnt_cycle !== 32'd0) begin fails++; $display("[TB] FAIL mid_cycle_a: got %0d expected 0", wb_a.cnt_cycle); end
        tests++; if (wb_a.cnt_instret !== 32'd0) begin fails++; $display("[TB] FAIL mid_instret_a: got %0d expected 0", wb_a.cnt_instret); end
        tests++; if (wb_a.retire_pc !== 32'd0) begin fails++; $display("[TB] FAIL mid_retire_pc_a: got %h expected 0", wb_a.retire_pc); end
        tests++; if (wb_b.cnt_cycle !== 64'd0) begin fails++; $display("[TB] FAIL mid_cycle_b: got %0d expected 0", wb_b.cnt_cycle); end
        tests++; if (wb_b.cnt_instret !== 64'd0) begin fails++; $display("[TB] FAIL mid_instret_b: got %0d expected 0", wb_b.cnt_instret); end
        tests++; if (wb_b.retire_pc !== 32'd0) begin fails++; $display("[TB] FAIL mid_retire_pc_b: got %h expected 0", wb_b.retire_pc); end
    endtask

    initial begin
        rst_n            = 1'b0;
        wb_a.mem_inst    = BUBBLE;
        wb_a.mem_dat     = 32'h0;
        wb_a.mem_pc      = 32'h0;
        wb_a.mem_exc_mis = 1'b0;
        wb_a.mem_exc_oob = 1'b0;
        wb_a.exc_clr     = 1'b0;
        wb_a.id_rs1      = 5'd0;
        wb_a.id_rs2      = 5'd0;
        test_reset();
        test_write_bypass();
        test_x0();
        test_store_branch();
        test_opcodes();
        test_exceptions();
        test_counter_wrap();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
